// File: rtl/dma_sample_packer.sv
// dma_sample_packer
//
// Decimates paired ADC samples (channels A/B), sign-extends each to 16 bits,
// packs two kept pairs into one 64-bit beat and buffers beats in a small FIFO
// with a valid/ready output. A capture stops after CAPTURE_WORDS beats have
// been pushed, then waits for the FIFO to drain.
//
// Optional feature (macro DMA_PACKER_SEQ_TAG_EN): a 2-bit beat sequence tag
// overwrites bits [15:14] and [47:46] of every formed beat.
//
// Ports:
//   clk                pdh_clk, rising-edge
//   rst_i              asynchronous active-high reset
//   enable_i           high starts/holds a capture, low aborts or re-arms
//   decimation_code_i  keep 1 of every (code+1) valid pairs, latched at start
//   sample_a_i/b_i     signed channel samples
//   sample_valid_i     sample pair valid this cycle
//   word_o             FIFO head beat (0 when empty)
//   word_valid_o       word_o valid
//   word_ready_i       downstream accepts word_o
//   word_count_o       beats pushed into the FIFO this capture
//   busy_o             capturing or draining
//   done_o             capture complete and FIFO drained
//   overflow_o         sticky: a beat was dropped on a full FIFO
module dma_sample_packer #(
  parameter int unsigned ADC_DATA_WIDTH = 14,
  parameter int unsigned DEC_WIDTH      = 26,
  parameter int unsigned CAPTURE_WORDS  = 2048,
  parameter int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned CNT_WIDTH     = $clog2(CAPTURE_WORDS + 1),
  localparam int unsigned PTR_WIDTH     = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [DEC_WIDTH-1:0]      decimation_code_i,
  input  logic [ADC_DATA_WIDTH-1:0] sample_a_i,
  input  logic [ADC_DATA_WIDTH-1:0] sample_b_i,
  input  logic                      sample_valid_i,
  output logic [63:0]               word_o,
  output logic                      word_valid_o,
  input  logic                      word_ready_i,
  output logic [CNT_WIDTH-1:0]      word_count_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overflow_o
);

  typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [DEC_WIDTH-1:0] dec_code_q, dec_code_d;
  logic [DEC_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
  logic                 half_q, half_d;
  logic [31:0]          half_data_q, half_data_d;
  logic [PTR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
`ifdef DMA_PACKER_SEQ_TAG_EN
  logic [1:0]           seq_q, seq_d;
`endif

  logic [63:0] mem [FIFO_DEPTH];
  logic        fifo_empty, fifo_full, pop, push;
  logic [31:0] lane;
  logic [63:0] beat;

  function automatic logic [15:0] sext(input logic [ADC_DATA_WIDTH-1:0] s);
    return 16'($signed(s));
  endfunction

  assign lane       = {sext(sample_b_i), sext(sample_a_i)};
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  // Same index, opposite lap bit.
  assign fifo_full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                      (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
  assign pop        = !fifo_empty && word_ready_i;

  always_comb begin
    state_d     = state_q;
    dec_code_d  = dec_code_q;
    dec_cnt_d   = dec_cnt_q;
    half_d      = half_q;
    half_data_d = half_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    beat        = {lane, half_data_q};
`ifdef DMA_PACKER_SEQ_TAG_EN
    seq_d       = seq_q;
    beat[15:14] = seq_q;
    beat[47:46] = seq_q;
`endif

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d    = StCapture;
          dec_code_d = decimation_code_i;
          dec_cnt_d  = '0;
          half_d     = 1'b0;
          count_d    = '0;
          overflow_d = 1'b0;
`ifdef DMA_PACKER_SEQ_TAG_EN
          seq_d      = 2'd0;
`endif
        end
      end
      StCapture: begin
        if (sample_valid_i) begin
          dec_cnt_d = (dec_cnt_q == dec_code_q) ? '0 : dec_cnt_q + DEC_WIDTH'(1);
          if (dec_cnt_q == '0) begin
            if (!half_q) begin
              half_d      = 1'b1;
              half_data_d = lane;
            end else begin
              half_d = 1'b0;
`ifdef DMA_PACKER_SEQ_TAG_EN
              seq_d  = seq_q + 2'd1;
`endif
              // A pop on the same edge frees a slot, so a full FIFO still accepts.
              if (!fifo_full || pop) begin
                push     = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + CNT_WIDTH'(1);
                if (count_d == CNT_WIDTH'(CAPTURE_WORDS)) begin
                  state_d = StDrain;
                end
              end else begin
                overflow_d = 1'b1;
              end
            end
          end
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!enable_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort: flush FIFO and half register; count and overflow hold.
    if (!enable_i && (state_q == StCapture || state_q == StDrain)) begin
      state_d  = StIdle;
      push     = 1'b0;
      half_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      dec_code_q  <= '0;
      dec_cnt_q   <= '0;
      half_q      <= 1'b0;
      half_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
`ifdef DMA_PACKER_SEQ_TAG_EN
      seq_q       <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      dec_code_q  <= dec_code_d;
      dec_cnt_q   <= dec_cnt_d;
      half_q      <= half_d;
      half_data_q <= half_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
`ifdef DMA_PACKER_SEQ_TAG_EN
      seq_q       <= seq_d;
`endif
    end
  end

  // Storage needs no reset: word_o is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[PTR_WIDTH-1:0]] <= beat;
    end
  end

  assign word_o       = fifo_empty ? '0 : mem[rd_ptr_q[PTR_WIDTH-1:0]];
  assign word_valid_o = !fifo_empty;
  assign word_count_o = count_q;
  assign busy_o       = (state_q == StCapture) || (state_q == StDrain);
  assign done_o       = (state_q == StDone);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_dma_sample_packer.sv
// Testbench for dma_sample_packer: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dma_sample_packer;

  localparam int unsigned ADC_W = 14;
  localparam int unsigned DEC_W = 26;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(CW + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [DEC_W-1:0] code = '0;
  logic [ADC_W-1:0] sa = '0;
  logic [ADC_W-1:0] sb = '0;
  logic             svalid = 1'b0;
  logic [63:0]      word;
  logic             word_valid;
  logic             word_ready = 1'b0;
  logic [CNT_W-1:0] word_count;
  logic             busy, done, overflow;

  int checks = 0;
  int errors = 0;

  dma_sample_packer #(
    .ADC_DATA_WIDTH(ADC_W),
    .DEC_WIDTH     (DEC_W),
    .CAPTURE_WORDS (CW),
    .FIFO_DEPTH    (DEPTH)
  ) u_dut (
    .clk              (clk),
    .rst_i            (rst),
    .enable_i         (enable),
    .decimation_code_i(code),
    .sample_a_i       (sa),
    .sample_b_i       (sb),
    .sample_valid_i   (svalid),
    .word_o           (word),
    .word_valid_o     (word_valid),
    .word_ready_i     (word_ready),
    .word_count_o     (word_count),
    .busy_o           (busy),
    .done_o           (done),
    .overflow_o       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_cap, m_drain, m_done;
  int          m_code, m_nvalid, m_count, m_seq;
  bit          m_half_v, m_ovf;
  logic [31:0] m_half;
  logic [63:0] m_q[$];

  function automatic logic [15:0] ext14(input logic [13:0] s);
    return s[13] ? {2'b11, s} : {2'b00, s};
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cap = 0; m_drain = 0; m_done = 0; m_half_v = 0; m_ovf = 0;
        m_count = 0; m_seq = 0; m_nvalid = 0; m_code = 0;
        m_q.delete();
      end else if (!m_cap && !m_drain && !m_done) begin
        if (enable) begin
          m_cap = 1; m_code = int'(code); m_nvalid = 0; m_half_v = 0;
          m_count = 0; m_ovf = 0; m_seq = 0;
        end
      end else if (m_done) begin
        if (!enable) m_done = 0;
      end else if (!enable) begin
        m_q.delete(); m_half_v = 0; m_cap = 0; m_drain = 0;
      end else begin
        automatic int          pre_size  = m_q.size();
        automatic bit          was_drain = m_drain;
        automatic logic [31:0] lane;
        automatic logic [63:0] beat;
        automatic logic [1:0]  tag;
        if (pre_size > 0 && word_ready) void'(m_q.pop_front());
        if (m_cap && svalid) begin
          if (m_nvalid % (m_code + 1) == 0) begin
            lane = {ext14(sb), ext14(sa)};
            if (!m_half_v) begin
              m_half = lane; m_half_v = 1;
            end else begin
              beat = {lane, m_half};
              tag  = 2'(m_seq % 4);
`ifdef DMA_PACKER_SEQ_TAG_EN
              beat[15:14] = tag;
              beat[47:46] = tag;
`endif
              m_seq++;
              m_half_v = 0;
              if (m_q.size() < DEPTH) begin
                m_q.push_back(beat);
                m_count++;
                if (m_count == CW) begin m_cap = 0; m_drain = 1; end
              end else begin
                m_ovf = 1;
              end
            end
          end
          m_nvalid++;
        end
        if (was_drain && pre_size == 0) begin m_drain = 0; m_done = 1; end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("word_valid", 64'(word_valid), 64'(m_q.size() > 0));
      check("word", word, (m_q.size() > 0) ? m_q[0] : 64'd0);
      check("word_count", 64'(word_count), 64'(m_count));
      check("busy", 64'(busy), 64'(m_cap || m_drain));
      check("done", 64'(done), 64'(m_done));
      check("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [13:0] a, input logic [13:0] b);
    sa = a; sb = b; svalid = 1'b1;
    tick();
    svalid = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    int          waited;
    #1 rst = 1'b1;
    tick(); tick();
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    rst = 1'b0;
    tick();

    // Packing / sign extension, code 0, full capture to DONE.
    code = '0; word_ready = 1'b1; enable = 1'b1;
    tick();
    send_pair(14'h1FFF, 14'h2000);
    send_pair(14'h0001, 14'h3FFF);
    check("beat0_literal", word, 64'hFFFF_0001_E000_1FFF);
    check("beat0_valid", 64'(word_valid), 64'd1);
    for (int i = 0; i < 14; i++) send_pair(14'(i * 37), 14'(14'h3FFF - i));
    waited = 0;
    while (!done && waited < 20) begin tick(); waited++; end
    check("done_reached", 64'(done), 64'd1);
    check("done_count", 64'(word_count), 64'd8);
    check("done_busy", 64'(busy), 64'd0);
    enable = 1'b0;
    tick();
    check("done_cleared", 64'(done), 64'd0);

    // Decimation code 2; a valid pair on the start cycle is ignored.
    code = 26'd2; word_ready = 1'b0; enable = 1'b1;
    sa = 14'h123; sb = 14'h123; svalid = 1'b1;
    tick();
    svalid = 1'b0;
    for (int i = 0; i < 12; i++) send_pair(14'(i), 14'(i));
    check("dec_count", 64'(word_count), 64'd2);
    check("dec_b0_lo", 64'(word[13:0]), 64'd0);
    check("dec_b0_hi", 64'(word[45:32]), 64'd3);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("dec_b1_lo", 64'(word[13:0]), 64'd6);
    check("dec_b1_hi", 64'(word[45:32]), 64'd9);
    // Abort with a beat still queued.
    enable = 1'b0;
    tick();
    check("abort_valid", 64'(word_valid), 64'd0);
    check("abort_count_hold", 64'(word_count), 64'd2);

    // Backpressure and overflow, code 0.
    code = '0; enable = 1'b1;
    tick();
    check("rearm_count", 64'(word_count), 64'd0);
    for (int i = 0; i < 12; i++) send_pair(14'(i + 1), 14'(i + 'h100));
    check("bp_count", 64'(word_count), 64'd4);
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_head", word, 64'h0101_0002_0100_0001);
    held = word;
    tick(); tick();
    check("bp_stable", word, held);
    word_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("bp_drained", 64'(word_valid), 64'd0);
    enable = 1'b0;
    tick();
    check("abort_ovf_hold", 64'(overflow), 64'd1);
    enable = 1'b1;
    tick();
    check("rearm_ovf_clear", 64'(overflow), 64'd0);

    // Asynchronous reset mid-capture with 3 beats queued.
    word_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pair(14'(i), 14'(i));
    check("pre_rst_count", 64'(word_count), 64'd3);
    enable = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("mid_rst_word", word, 64'd0);
    check("mid_rst_valid", 64'(word_valid), 64'd0);
    check("mid_rst_count", 64'(word_count), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

`ifdef DMA_PACKER_SEQ_TAG_EN
    code = '0; word_ready = 1'b1; enable = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      send_pair(14'(k), 14'(k));
      send_pair(14'(k), 14'(k));
      check("tag_lo", 64'(word[15:14]), 64'(k % 4));
      check("tag_hi", 64'(word[47:46]), 64'(k % 4));
    end
    enable = 1'b0;
    tick();
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
